// File: rtl/period_uart_reporter.sv
// Converts a 16-bit period to "P=ddddd\r\n" and sends it 8N1; start bit 17 cycles after capture, 17+90*CLKS_PER_BIT busy.
// No backpressure: a strobe while busy is dropped and latches the sticky overrun flag.
module period_uart_reporter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk_50mhz,
    input  logic        rst,
    input  logic [15:0] period_us,
    input  logic        period_valid,
    output logic        busy,
    output logic        overrun,
    output logic        uart_tx_pin
);

    typedef enum logic [1:0] {IDLE, CONVERT, LOAD, SEND} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    logic [19:0] bcd;
    logic [15:0] bin;
    logic [3:0]  bit_cnt;
    logic [3:0]  byte_idx;
    logic [15:0] baud_cnt;

    logic [19:0] bcd_adj;
    logic [3:0]  digit;
    logic [7:0]  cur_byte;

    // Double-dabble correction: bump any nibble >= 5 by 3 before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        digit = 4'd0;
        case (byte_idx)
            4'd2:    digit = bcd[19:16];
            4'd3:    digit = bcd[15:12];
            4'd4:    digit = bcd[11:8];
            4'd5:    digit = bcd[7:4];
            4'd6:    digit = bcd[3:0];
            default: digit = 4'd0;
        endcase
    end

    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx)
            4'd0:                          cur_byte = 8'h50;
            4'd1:                          cur_byte = 8'h3D;
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6: cur_byte = {4'h3, digit};
            4'd7:                          cur_byte = 8'h0D;
            default:                       cur_byte = 8'h0A;
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state       <= IDLE;
            bcd         <= '0;
            bin         <= '0;
            bit_cnt     <= '0;
            byte_idx    <= '0;
            baud_cnt    <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            uart_tx_pin <= 1'b1;
        end else begin
            if (period_valid && busy) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (period_valid) begin
                        bin     <= period_us;
                        bcd     <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    bit_cnt    <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    uart_tx_pin <= 1'b0;
                    byte_idx    <= '0;
                    bit_cnt     <= '0;
                    baud_cnt    <= '0;
                    state       <= SEND;
                end
                SEND: begin
                    // bit_cnt: 0 = start, 1..8 = data LSB first, 9 = stop
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            if (byte_idx == 4'd8) begin
                                state       <= IDLE;
                                busy        <= 1'b0;
                                uart_tx_pin <= 1'b1;
                            end else begin
                                byte_idx    <= byte_idx + 4'd1;
                                bit_cnt     <= '0;
                                uart_tx_pin <= 1'b0;
                            end
                        end else begin
                            bit_cnt     <= bit_cnt + 4'd1;
                            uart_tx_pin <= (bit_cnt == 4'd8) ? 1'b1 : cur_byte[bit_cnt[2:0]];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_period_uart_reporter.sv
// Randomised scoreboard bench: expected frame bytes are queued at each accepted strobe and popped by a mid-bit UART decoder.
module tb_period_uart_reporter;

    localparam int CPB = 4;

    logic        clk_50mhz = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] period_us = '0;
    logic        period_valid = 1'b0;
    logic        busy;
    logic        overrun;
    logic        uart_tx_pin;

    int checks = 0;
    int errors = 0;
    int epoch = 0;
    logic [7:0] exp_q[$];

    period_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
        .clk_50mhz    (clk_50mhz),
        .rst          (rst),
        .period_us    (period_us),
        .period_valid (period_valid),
        .busy         (busy),
        .overrun      (overrun),
        .uart_tx_pin  (uart_tx_pin)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference frame: "P=" + five decimal digits (leading zeros) + CR LF
    task automatic push_frame(input logic [15:0] v);
        int val;
        int div;
        val = int'(v);
        div = 10000;
        exp_q.push_back(8'h50);
        exp_q.push_back(8'h3D);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'((val / div) % 10 + 48));
            div = div / 10;
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic step;
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic strobe(input logic [15:0] v, input bit expect_frame);
        period_us    = v;
        period_valid = 1'b1;
        if (expect_frame) push_frame(v);
        step;
        period_valid = 1'b0;
        period_us    = 16'($urandom);
    endtask

    task automatic frame_timing(input logic [15:0] v);
        int k;
        bit early_low;
        strobe(v, 1'b1);
        check("busy_after_capture", int'(busy), 1);
        early_low = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            step;
            if (!uart_tx_pin) early_low = 1'b1;
        end
        check("tx_high_during_convert", int'(early_low), 0);
        step;
        check("start_bit_at_e17", int'(uart_tx_pin), 0);
        k = 17;
        while (busy && k < 2000) begin
            step;
            k++;
        end
        check("busy_cycles", k, 17 + 90 * CPB);
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while (busy && n < 2000) begin
            step;
            n++;
        end
        check("idle_reached", int'(busy), 0);
    endtask

    // Monitor: mid-bit UART decoder, compares each byte against the scoreboard
    initial begin
        int ep;
        logic [7:0] b;
        logic start_b;
        logic stop_b;
        forever begin
            @(negedge clk_50mhz);
            if (!uart_tx_pin && !rst) begin
                ep = epoch;
                repeat (CPB / 2) @(negedge clk_50mhz);
                start_b = uart_tx_pin;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk_50mhz);
                    b[i] = uart_tx_pin;
                end
                repeat (CPB) @(negedge clk_50mhz);
                stop_b = uart_tx_pin;
                if (ep == epoch) begin
                    check("start_bit_level", int'(start_b), 0);
                    check("stop_bit_level", int'(stop_b), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %02h expected none", b);
                    end else begin
                        check("uart_byte", int'(b), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) step;
        check("reset_tx", int'(uart_tx_pin), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);
        rst = 1'b0;
        step;

        frame_timing(16'd1590);
        check("no_overrun_single", int'(overrun), 0);
        frame_timing(16'd0);
        frame_timing(16'd65535);
        frame_timing(16'd9);

        // Strobe at cycle 100 of a frame is dropped and flags overrun
        strobe(16'd1590, 1'b1);
        repeat (99) step;
        strobe(16'd1234, 1'b0);
        wait_idle;
        check("overrun_set", int'(overrun), 1);
        frame_timing(16'd1234);
        check("overrun_sticky", int'(overrun), 1);

        // Reset during byte 4 abandons the frame
        strobe(16'd1590, 1'b1);
        repeat (150) step;
        rst = 1'b1;
        epoch++;
        exp_q.delete();
        step;
        check("midreset_tx", int'(uart_tx_pin), 1);
        check("midreset_busy", int'(busy), 0);
        check("midreset_overrun", int'(overrun), 0);
        rst = 1'b0;
        repeat (50) step;
        frame_timing(16'd42);
        check("overrun_after_reset", int'(overrun), 0);

        // Strobe on the edge that ends the last stop bit
        strobe(16'd500, 1'b1);
        repeat (376) step;
        strobe(16'd777, 1'b0);
        check("busy_fell_edge", int'(busy), 0);
        check("overrun_last_cycle", int'(overrun), 1);
        repeat (20) step;
        check("no_second_frame", int'(busy), 0);

        // Strobe one cycle after busy falls is accepted
        strobe(16'd321, 1'b1);
        repeat (377) step;
        check("busy_low_before_b2b", int'(busy), 0);
        frame_timing(16'd654);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) step;
            frame_timing(16'($urandom));
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step;
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/period_uart_reporter.md
# period_uart_reporter

Downstream reporting stage of the pulsar decoder. Accepts a detected pulsar period (binary, microseconds) from the FFA/period-detection stage, converts it to fixed-width decimal ASCII, and transmits the frame `P=ddddd<CR><LF>` on an 8N1 UART line. It drives the board-level `uart_tx_pin` and owns all serial timing.

## Interface

Parameters:
- CLKS_PER_BIT, 434: clock cycles per UART bit. 434 gives 115200 baud at 50 MHz. Legal range is 2 to 65535.

Ports:
- clk_50mhz  in  1  system clock, 50 MHz.
- rst  in  1  reset; synchronous, active-high.
- period_us  in  16  detected period in µs, unsigned, range 0–65535.
- period_valid  in  1  single-cycle strobe qualifying period_us.
- busy  out  1  high from capture until the last stop bit ends.
- overrun  out  1  sticky; set when period_valid arrives while busy. Cleared only by rst.
- uart_tx_pin  out  1  serial output. Idles high.

## Operation

- Reset values: uart_tx_pin=1, busy=0, overrun=0. The FSM returns to IDLE and all counters clear.
- States:
  - IDLE → CONVERT: on period_valid=1 with busy=0. The block latches period_us and busy=1 on the next edge.
  - CONVERT: iterative double-dabble over exactly 16 cycles, one bit per cycle. It produces 5 BCD digits with leading zeros kept.
  - CONVERT → SEND: the frame loads into a 9-byte sequence: 0x50 'P', 0x3D '=', five digits as 0x30+d (most significant first), 0x0D, 0x0A.
  - SEND: each byte is sent as a start bit (0), then 8 data bits LSB first, then a stop bit (1). Each bit lasts CLKS_PER_BIT cycles.
  - SEND → next byte: the next byte's start bit follows the previous stop bit immediately, with no idle gap.
  - SEND → IDLE: after byte 9's stop bit completes.
- The input is captured only in IDLE. A period_valid that arrives while busy=1 is dropped, sets overrun, and leaves the frame in progress unaffected.
- period_us is don't-care except in the capture cycle.
- Reset mid-frame: on the next edge the line returns high, busy drops, and the partial frame is abandoned with no completion. A subsequent period_valid is accepted normally.
- Arithmetic: the BCD shift register is 20 bits plus a 16-bit binary. The add-3 correction applies per nibble when the nibble is ≥5, before each shift. The bit counter is 4 bits, the byte index 4 bits, and the baud counter 16 bits.

## Timing

- Edge E0 is the edge that samples period_valid=1 with busy=0.
- busy=1 from after E0.
- CONVERT occupies E1–E16.
- uart_tx_pin falls (first start bit) after E17.
- Each bit holds for exactly CLKS_PER_BIT cycles.
- busy falls on the same edge that ends the final stop bit, which is E17 + 90·CLKS_PER_BIT. Total busy = 17 + 90·CLKS_PER_BIT cycles. This is 39077 cycles (≈781.5 µs) at the default.
- Simultaneous events:
  - period_valid in the cycle where busy is still 1 (including the final stop-bit cycle) counts as an overrun.
  - period_valid in the first cycle after busy falls is accepted.
- rst has priority over period_valid in the same cycle.
- uart_tx_pin is registered and glitch-free.

## Test plan

Run with CLKS_PER_BIT=4 unless noted. The bench UART decoder samples at mid-bit.

- period_us=1590, one strobe → decoded bytes 50 3D 30 31 35 39 30 0D 0A. First start bit after E17. busy high for exactly 17+360=377 cycles. overrun=0.
- Boundary values: 0 → "P=00000". 65535 → "P=65535". 9 → "P=00009". Each gives the correct 9-byte frame.
- Strobe of 1234 at cycle 100 of a 1590 frame → 1590 frame intact, overrun=1 sticky. A strobe of 1234 after busy falls yields "P=01234".
- Strobe in the exact cycle busy falls → overrun=1, no second frame. Strobe one cycle later → accepted, start bit 17 edges later.
- rst pulsed during byte 4 → uart_tx_pin=1 and busy=0 on the next edge, overrun cleared. A new strobe of 42 → clean "P=00042" frame.
- Default CLKS_PER_BIT=434 with 1590 → bit width 8.68 µs. Frame completes 781.54 µs after capture.
